// File: rtl/branch_predictor_if.sv
// Fetch/execute-side bundle for the branch predictor: lookup, resolution and statistics.
// The pipeline drives the master side; the predictor implements the slave side.
interface branch_predictor_if #(
    parameter int WIDTH = 32
);
    logic             en;
    logic [WIDTH-1:0] ifPC;
    logic             predictJump;
    logic [WIDTH-1:0] predictPC;
    logic             exValid;
    logic [WIDTH-1:0] exPC;
    logic [WIDTH-1:0] exTarget;
    logic [WIDTH-1:0] exPredPC;
    logic             exTaken;
    logic             exPredicted;
    logic             mispredict;
    logic [WIDTH-1:0] flushPC;
    logic [31:0]      branchCount;
    logic [31:0]      missCount;

    modport master (
        output en, ifPC, exValid, exPC, exTarget, exPredPC, exTaken, exPredicted,
        input  predictJump, predictPC, mispredict, flushPC, branchCount, missCount
    );

    modport slave (
        input  en, ifPC, exValid, exPC, exTarget, exPredPC, exTaken, exPredicted,
        output predictJump, predictPC, mispredict, flushPC, branchCount, missCount
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters, mispredict detection and statistics.
// The table is register-based because reset must clear every entry in one cycle.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int WIDTH   = 32
) (
    input logic               clk,
    input logic               rst,
    branch_predictor_if.slave bus
);
    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = WIDTH - IDXW - 2;

    logic             valid_reg  [ENTRIES];
    logic [TAGW-1:0]  tag_reg    [ENTRIES];
    logic [WIDTH-1:0] target_reg [ENTRIES];
    logic [1:0]       ctr_reg    [ENTRIES];
    logic [31:0]      branch_count_reg;
    logic [31:0]      miss_count_reg;

    logic [IDXW-1:0]  if_idx;
    logic [IDXW-1:0]  ex_idx;
    logic [TAGW-1:0]  if_tag;
    logic [TAGW-1:0]  ex_tag;
    logic             if_hit;
    logic             ex_hit;
    logic             update;
    logic             mispredict_next;
    logic             unused_low_bits;

    assign if_idx = bus.ifPC[IDXW+1:2];
    assign if_tag = bus.ifPC[WIDTH-1:IDXW+2];
    assign ex_idx = bus.exPC[IDXW+1:2];
    assign ex_tag = bus.exPC[WIDTH-1:IDXW+2];
    assign unused_low_bits = &{1'b0, bus.ifPC[1:0], bus.exPC[1:0]};

    // Lookup reads the registered table, so a same-cycle update is not yet visible.
    assign if_hit = valid_reg[if_idx] && (tag_reg[if_idx] == if_tag);
    assign ex_hit = valid_reg[ex_idx] && (tag_reg[ex_idx] == ex_tag);
    assign update = bus.en && bus.exValid;

    assign bus.predictJump = if_hit && ctr_reg[if_idx][1];
    assign bus.predictPC   = bus.predictJump ? target_reg[if_idx] : bus.ifPC + WIDTH'(4);

    assign mispredict_next = bus.exValid &&
                             (bus.exTaken ? (!bus.exPredicted || (bus.exPredPC != bus.exTarget))
                                          : bus.exPredicted);
    assign bus.mispredict  = mispredict_next;
    assign bus.flushPC     = bus.exTaken ? bus.exTarget : bus.exPC + WIDTH'(4);

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic sel;
            assign sel = update && (ex_idx == IDXW'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg[gi]  <= 1'b0;
                    tag_reg[gi]    <= '0;
                    target_reg[gi] <= '0;
                    ctr_reg[gi]    <= 2'b00;
                end else if (sel) begin
                    if (ex_hit) begin
                        if (bus.exTaken) begin
                            target_reg[gi] <= bus.exTarget;
                            if (ctr_reg[gi] != 2'b11)
                                ctr_reg[gi] <= ctr_reg[gi] + 2'b01;
                        end else if (ctr_reg[gi] != 2'b00) begin
                            ctr_reg[gi] <= ctr_reg[gi] - 2'b01;
                        end
                    end else if (bus.exTaken) begin
                        // Taken miss replaces whatever aliased here, starting weakly taken.
                        valid_reg[gi]  <= 1'b1;
                        tag_reg[gi]    <= ex_tag;
                        target_reg[gi] <= bus.exTarget;
                        ctr_reg[gi]    <= 2'b10;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count_reg <= '0;
            miss_count_reg   <= '0;
        end else if (update) begin
            branch_count_reg <= branch_count_reg + 32'd1;
            if (mispredict_next)
                miss_count_reg <= miss_count_reg + 32'd1;
        end
    end

    assign bus.branchCount = branch_count_reg;
    assign bus.missCount   = miss_count_reg;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: reset, allocation, counter hysteresis,
// aliasing, stall behaviour and reset-abort, with hand-computed expectations.
module tb_branch_predictor;
    logic clk;
    logic rst;
    int   checks_total;
    int   checks_passed;

    branch_predictor_if #(.WIDTH(32)) bus ();

    branch_predictor #(.ENTRIES(16), .WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
            $display("ok   %-24s got=0x%08h", tag, got);
        end else begin
            $display("FAIL %-24s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                           input logic predicted, input logic [31:0] pred_pc);
        bus.exValid     = 1'b1;
        bus.exPC        = pc;
        bus.exTaken     = taken;
        bus.exTarget    = target;
        bus.exPredicted = predicted;
        bus.exPredPC    = pred_pc;
    endtask

    task automatic lookup(input logic [31:0] pc, input logic exp_jump, input logic [31:0] exp_pc,
                          input string tag);
        bus.ifPC = pc;
        #1;
        check({tag, ".jump"}, 32'(bus.predictJump), 32'(exp_jump));
        check({tag, ".pc"}, bus.predictPC, exp_pc);
    endtask

    task automatic counts(input logic [31:0] b, input logic [31:0] m, input string tag);
        check({tag, ".branches"}, bus.branchCount, b);
        check({tag, ".misses"}, bus.missCount, m);
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst = 1'b1;
        bus.en = 1'b1;
        bus.ifPC = 32'h100;
        resolve(32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        bus.exValid = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        lookup(32'h100, 1'b0, 32'h104, "reset");
        counts(0, 0, "reset");

        // Taken miss allocates; same-cycle lookup sees pre-update state
        resolve(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        lookup(32'h100, 1'b0, 32'h104, "alloc.same_cycle");
        check("alloc.mispredict", 32'(bus.mispredict), 1);
        check("alloc.flushPC", bus.flushPC, 32'h200);
        step();
        bus.exValid = 1'b0;
        lookup(32'h100, 1'b1, 32'h200, "alloc.next");
        counts(1, 1, "alloc");

        // Not-taken updates: 10 -> 01 -> 00 -> 00
        resolve(32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
        #1;
        check("nt1.mispredict", 32'(bus.mispredict), 1);
        check("nt1.flushPC", bus.flushPC, 32'h104);
        step();
        lookup(32'h100, 1'b0, 32'h104, "nt1");
        counts(2, 2, "nt1");
        resolve(32'h100, 1'b0, 32'h0, 1'b0, 32'h104);
        #1;
        check("nt2.mispredict", 32'(bus.mispredict), 0);
        step();
        step();
        counts(4, 2, "nt3");
        // From saturated 00 one taken gives 01 (not taken), a second gives 10
        resolve(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        step();
        bus.exValid = 1'b0;
        lookup(32'h100, 1'b0, 32'h104, "sat.t1");
        resolve(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        step();
        bus.exValid = 1'b0;
        lookup(32'h100, 1'b1, 32'h200, "sat.t2");
        counts(6, 4, "sat");

        // Aliasing: 0x140 shares index 0 with 0x100 and replaces it
        resolve(32'h140, 1'b1, 32'h500, 1'b0, 32'h144);
        step();
        bus.exValid = 1'b0;
        lookup(32'h100, 1'b0, 32'h104, "alias.old");
        lookup(32'h140, 1'b1, 32'h500, "alias.new");
        counts(7, 5, "alias");

        // Wrong predicted target flags mispredict even with en=0; stall changes nothing
        bus.en = 1'b0;
        resolve(32'h140, 1'b1, 32'h200, 1'b1, 32'h300);
        #1;
        check("stall.mispredict", 32'(bus.mispredict), 1);
        check("stall.flushPC", bus.flushPC, 32'h200);
        step();
        bus.en = 1'b1;
        bus.exValid = 1'b0;
        lookup(32'h140, 1'b1, 32'h500, "stall.table");
        counts(7, 5, "stall");

        // Correct taken prediction is not a mispredict
        resolve(32'h140, 1'b1, 32'h500, 1'b1, 32'h500);
        #1;
        check("hit.mispredict", 32'(bus.mispredict), 0);
        step();
        counts(8, 5, "hit");

        // Not-taken miss does not allocate
        resolve(32'h108, 1'b0, 32'h0, 1'b0, 32'h10c);
        step();
        bus.exValid = 1'b0;
        lookup(32'h108, 1'b0, 32'h10c, "nt_miss");
        counts(9, 5, "nt_miss");

        // Fall-through and flush PC wrap modulo 2^32
        lookup(32'hFFFF_FFFC, 1'b0, 32'h0, "wrap");
        resolve(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
        bus.en = 1'b0;
        #1;
        check("wrap.flushPC", bus.flushPC, 32'h0);
        bus.en = 1'b1;

        // Reset aborts an in-flight allocation
        rst = 1'b1;
        resolve(32'h104, 1'b1, 32'h600, 1'b0, 32'h108);
        step();
        rst = 1'b0;
        bus.exValid = 1'b0;
        lookup(32'h104, 1'b0, 32'h108, "rst.inflight");
        lookup(32'h140, 1'b0, 32'h144, "rst.table");
        counts(0, 0, "rst");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
